// File: rtl/spi_byte_queue.sv
// spi_byte_queue: {dc, end_txn, byte} queue that launches entries into the SPI controller.
// Define SPI_QUEUE_RX_EN to build the read-back capture registers.
module spi_byte_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   input  logic [7:0]    wr_data,
   input  logic          wr_dc,
   input  logic          wr_end_txn,
   output logic          wr_ready,
   input  logic          flush,
   output logic [AW:0]   count,
   output logic          idle,
   output logic          spi_start,
   output logic [7:0]    spi_data_in,
   output logic          spi_dc_in,
   output logic          spi_end_txn,
   input  logic          spi_busy,
   input  logic [7:0]    spi_data_out,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   input  logic          rd_ack,
   output logic          rx_overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_XFER
   } state_t;

   state_t        state, state_nx;
   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          full, empty;
   logic          push, launch, capture;

   assign full     = (cnt == (AW+1)'(DEPTH));
   assign empty    = (cnt == '0);
   assign wr_ready = !full;
   assign count    = cnt;
   assign idle     = empty && (state == S_IDLE) && !spi_busy;

   // flush wins over a same-cycle push; a launch still pops the head
   assign push    = wr_valid && !full && !flush;
   assign launch  = (state == S_IDLE) && !empty && !spi_busy;
   assign capture = (state == S_XFER) && !spi_busy;

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (launch)    state_nx = S_LAUNCH;
         S_LAUNCH: if (spi_busy)  state_nx = S_XFER;
         S_XFER:   if (!spi_busy) state_nx = S_IDLE;
         default:                 state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {wr_dc, wr_end_txn, wr_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (flush) begin
            rp  <= wp;
            cnt <= '0;
         end else begin
            if (launch) rp <= rp + 1'b1;
            if (push && !launch)      cnt <= cnt + 1'b1;
            else if (!push && launch) cnt <= cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spi_start   <= 1'b0;
         spi_data_in <= '0;
         spi_dc_in   <= 1'b0;
         spi_end_txn <= 1'b0;
      end else begin
         spi_start <= launch;
         if (launch) {spi_dc_in, spi_end_txn, spi_data_in} <= mem[rp];
      end
   end

`ifdef SPI_QUEUE_RX_EN
   // an ack coinciding with a capture keeps the new byte and clears overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data     <= '0;
         rd_valid    <= 1'b0;
         rx_overflow <= 1'b0;
      end else begin
         if (capture) begin
            rd_data  <= spi_data_out;
            rd_valid <= 1'b1;
         end else if (rd_ack) begin
            rd_valid <= 1'b0;
         end
         if (rd_ack)                   rx_overflow <= 1'b0;
         else if (capture && rd_valid) rx_overflow <= 1'b1;
      end
   end
`else
   logic unused_rx;

   assign unused_rx   = ^{rd_ack, spi_data_out, capture};
   assign rd_data     = '0;
   assign rd_valid    = 1'b0;
   assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_queue.sv
// tb_spi_byte_queue: scoreboard bench with a small SPI controller model.
// Read-back expectations follow whether SPI_QUEUE_RX_EN is defined.
module tb_spi_byte_queue;

   localparam int DEPTH = 4;
`ifdef SPI_QUEUE_RX_EN
   localparam bit RX = 1'b1;
`else
   localparam bit RX = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = '0;
   logic       wr_dc = 1'b0;
   logic       wr_end_txn = 1'b0;
   logic       wr_ready;
   logic       flush = 1'b0;
   logic [2:0] count;
   logic       idle;
   logic       spi_start;
   logic [7:0] spi_data_in;
   logic       spi_dc_in;
   logic       spi_end_txn;
   logic       spi_busy;
   logic [7:0] spi_data_out;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ack = 1'b0;
   logic       rx_overflow;

   logic       mbusy;
   logic       hold_busy = 1'b0;
   logic [1:0] rem;
   logic [7:0] resp;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         n_start = 0;
   logic [9:0] lq[$];
   logic [7:0] rxq[$];
   logic       gap_chk = 1'b0;
   logic       pend = 1'b0;

   spi_byte_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_dc        (wr_dc),
      .wr_end_txn   (wr_end_txn),
      .wr_ready     (wr_ready),
      .flush        (flush),
      .count        (count),
      .idle         (idle),
      .spi_start    (spi_start),
      .spi_data_in  (spi_data_in),
      .spi_dc_in    (spi_dc_in),
      .spi_end_txn  (spi_end_txn),
      .spi_busy     (spi_busy),
      .spi_data_out (spi_data_out),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_ack       (rd_ack),
      .rx_overflow  (rx_overflow)
   );

   always #5 clk = ~clk;

   assign spi_busy     = mbusy | hold_busy;
   assign spi_data_out = resp;

   // controller model: busy for 3 cycles after start, answers byte ^ 0x99
   always @(posedge clk) begin
      if (rst) begin
         mbusy <= 1'b0;
         rem   <= '0;
         resp  <= '0;
      end else if (spi_start) begin
         mbusy <= 1'b1;
         rem   <= 2'd3;
         resp  <= spi_data_in ^ 8'h99;
      end else if (mbusy) begin
         if (rem > 2'd1) rem <= rem - 2'd1;
         else            mbusy <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   initial begin : monitor
      logic       prev_mbusy;
      logic       prev_rst;
      logic       prev_start;
      logic       fall_ok;
      int         fall_cyc;
      logic [9:0] e;
      logic [7:0] r;
      prev_mbusy = 1'b0;
      prev_rst   = 1'b1;
      prev_start = 1'b0;
      fall_ok    = 1'b0;
      fall_cyc   = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            rxq.delete();
            pend = 1'b0;
         end else begin
            if (pend) begin
               pend = 1'b0;
               chk("rx_expected", 32'(rxq.size() != 0), 1);
               if (rxq.size() != 0) begin
                  r = rxq.pop_front();
                  chk("rx_valid", 32'(rd_valid), 32'(RX));
                  chk("rx_data", 32'(rd_data), RX ? 32'(r) : 0);
               end
            end
            if (prev_mbusy && !mbusy && !prev_rst) begin
               pend = 1'b1;
               if (gap_chk) begin
                  fall_cyc = cyc;
                  fall_ok  = 1'b1;
               end
            end
            if (spi_start) begin
               n_start++;
               chk("start_width", 32'(prev_start), 0);
               chk("launch_expected", 32'(lq.size() != 0), 1);
               if (lq.size() != 0) begin
                  e = lq.pop_front();
                  chk("launch_entry",
                      32'({spi_dc_in, spi_end_txn, spi_data_in}),
                      32'(e));
                  rxq.push_back(e[7:0] ^ 8'h99);
               end
               if (gap_chk && fall_ok) chk("gap", 32'(cyc - fall_cyc), 2);
               fall_ok = 1'b0;
            end
         end
         if (!gap_chk) fall_ok = 1'b0;
         prev_mbusy = mbusy;
         prev_rst   = rst;
         prev_start = spi_start;
      end
   end

   task automatic push(input logic dc, input logic en,
                       input logic [7:0] d, input bit launch);
      wr_dc      = dc;
      wr_end_txn = en;
      wr_data    = d;
      wr_valid   = 1'b1;
      if (launch) lq.push_back({dc, en, d});
      @(posedge clk);
      #1 wr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (!(idle && lq.size() == 0 && rxq.size() == 0 && !pend)
                 && i < 200);
      chk("wait_idle", 32'(i < 200), 1);
   endtask

   task automatic ack();
      @(negedge clk);
      rd_ack = 1'b1;
      @(posedge clk);
      #1 rd_ack = 1'b0;
      @(negedge clk);
      chk("ack_valid", 32'(rd_valid), 0);
      chk("ack_ovf", 32'(rx_overflow), 0);
   endtask

   initial begin
      int s0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_start", 32'(spi_start), 0);
      chk("rst_data_in", 32'(spi_data_in), 0);
      chk("rst_dc_end", 32'({spi_dc_in, spi_end_txn}), 0);
      chk("rst_rx", 32'({rd_data, rd_valid, rx_overflow}), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_wr_ready", 32'(wr_ready), 1);
      chk("rst_idle", 32'(idle), 1);

      // single byte: latency and read-back
      push(1'b1, 1'b0, 8'hA5, 1'b1);
      @(negedge clk);
      chk("t1_count", 32'(count), 1);
      chk("t1_start_early", 32'(spi_start), 0);
      @(negedge clk);
      chk("t1_start", 32'(spi_start), 1);
      wait_idle();
      chk("t1_rd_valid", 32'(rd_valid), 32'(RX));
      chk("t1_rd_data", 32'(rd_data), RX ? 32'h3C : 0);
      ack();

      // two captures without ack -> overflow
      push(1'b0, 1'b1, 8'h5A, 1'b1);
      push(1'b1, 1'b1, 8'h81, 1'b1);
      wait_idle();
      chk("t3_ovf", 32'(rx_overflow), 32'(RX));
      chk("t3_rd_data", 32'(rd_data), RX ? 32'h18 : 0);
      ack();

      // fill while controller busy, fifth push dropped
      hold_busy = 1'b1;
      push(1'b0, 1'b0, 8'h01, 1'b1);
      push(1'b1, 1'b0, 8'h02, 1'b1);
      push(1'b0, 1'b1, 8'h03, 1'b1);
      push(1'b1, 1'b1, 8'h04, 1'b1);
      @(negedge clk);
      chk("t2_wr_ready", 32'(wr_ready), 0);
      chk("t2_count_full", 32'(count), 4);
      chk("t2_idle", 32'(idle), 0);
      push(1'b0, 1'b0, 8'h05, 1'b0);
      @(negedge clk);
      chk("t2_count_drop", 32'(count), 4);
      gap_chk   = 1'b1;
      hold_busy = 1'b0;
      wait_idle();
      gap_chk = 1'b0;
      ack();

      // push and launch in the same cycle, pointers wrap 3 -> 0
      hold_busy = 1'b1;
      push(1'b0, 1'b1, 8'h11, 1'b1);
      push(1'b1, 1'b0, 8'h22, 1'b1);
      @(negedge clk);
      chk("t5_count2", 32'(count), 2);
      hold_busy = 1'b0;
      push(1'b1, 1'b1, 8'h33, 1'b1);
      @(negedge clk);
      chk("t5_count_same", 32'(count), 2);
      wait_idle();
      ack();

      // flush during first transfer
      push(1'b0, 1'b0, 8'hC7, 1'b1);
      push(1'b1, 1'b0, 8'hD8, 1'b0);
      push(1'b0, 1'b1, 8'hE9, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("t4_count", 32'(count), 0);
      s0 = n_start;
      repeat (20) @(negedge clk);
      chk("t4_no_start", 32'(n_start - s0), 0);
      chk("t4_rd_valid", 32'(rd_valid), 32'(RX));
      chk("t4_rd_data", 32'(rd_data), RX ? 32'h5E : 0);
      chk("t4_idle", 32'(idle), 1);
      ack();

      // reset during XFER
      push(1'b1, 1'b1, 8'h7E, 1'b1);
      push(1'b0, 1'b0, 8'h42, 1'b0);
      s0 = 0;
      while (!spi_busy && s0 < 20) begin
         @(negedge clk);
         s0++;
      end
      chk("t6_busy_seen", 32'(spi_busy), 1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_start", 32'(spi_start), 0);
      chk("t6_data_in", 32'(spi_data_in), 0);
      chk("t6_dc_end", 32'({spi_dc_in, spi_end_txn}), 0);
      chk("t6_rx", 32'({rd_data, rd_valid, rx_overflow}), 0);
      chk("t6_count", 32'(count), 0);
      chk("t6_wr_ready", 32'(wr_ready), 1);
      chk("t6_idle", 32'(idle), 1);
      s0 = n_start;
      repeat (10) @(negedge clk);
      chk("t6_no_start", 32'(n_start - s0), 0);
      chk("end_lq_empty", 32'(lq.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
